// File: rtl/ccff_chain_loader_if.sv
// Bitstream-side bundle of the chain loader: start strobes, load word
// stream, readback word stream and status.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              start_load;
  logic              start_read;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;
  logic              busy;
  logic              done;

  // Front-end (DMA/JTAG) side
  modport master (
    output start_load, start_read, cfg_data, cfg_valid, rb_ready,
    input  cfg_ready, rb_data, rb_valid, busy, done
  );

  // Loader side
  modport slave (
    input  start_load, start_read, cfg_data, cfg_valid, rb_ready,
    output cfg_ready, rb_data, rb_valid, busy, done
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises load words into ccff_head (LSB
// first) and, in readback, recirculates ccff_tail into ccff_head while
// collecting the tail bits back into words. The chain shifts only in
// cycles where chain_clk_en is high.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 62,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  ccff_chain_loader_if.slave bus,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
  localparam logic [BW-1:0]    FULL = BW'(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;          // shifts issued this operation
  logic [WORD_W-1:0] buf_q, buf_d;        // load: unsent bits; read: collected bits
  logic [BW-1:0]     bcnt, bcnt_d;        // bits held in buf_q
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  logic [CNT_W-1:0]  pending;
  logic              cfg_ready_c;
  logic              accept;
  logic              slot_free;
  logic [WORD_W-1:0] src, cap;
  logic [BW-1:0]     src_cnt, cap_cnt;
  logic              word_done;

  // Bits already issued plus bits still buffered; a new word is only
  // wanted while this does not yet cover the whole chain.
  assign pending     = cnt + CNT_W'(bcnt);
  assign cfg_ready_c = (state == LOAD) && (bcnt <= BW'(1)) && (pending < LEN);
  assign accept      = cfg_ready_c && bus.cfg_valid;
  assign slot_free   = !rb_valid_q || bus.rb_ready;

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.rb_data   = rb_data_q;
  assign bus.rb_valid  = rb_valid_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign chain_clk_en  = en_q;
  assign ccff_head     = (state == READ) ? ccff_tail : head_q;

  // Next-state, shift scheduling and word assembly
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    buf_d      = buf_q;
    bcnt_d     = bcnt;
    head_d     = head_q;
    en_d       = 1'b0;
    rb_data_d  = rb_data_q;
    rb_valid_d = rb_valid_q;
    src        = buf_q;
    src_cnt    = bcnt;
    cap        = buf_q;
    cap_cnt    = bcnt;
    word_done  = 1'b0;

    if (rb_valid_q && bus.rb_ready) rb_valid_d = 1'b0;

    case (state)
      IDLE: begin
        cnt_d  = '0;
        buf_d  = '0;
        bcnt_d = '0;
        if (bus.start_load)      state_d = LOAD;
        else if (bus.start_read) state_d = READ;
      end

      LOAD: begin
        // An empty buffer issues bit 0 of the incoming word directly so
        // streaming has no refill bubble; with one bit left, that bit is
        // issued and the new word replaces the buffer in the same edge.
        if (accept && bcnt == '0) begin
          src     = bus.cfg_data;
          src_cnt = FULL;
        end
        if (cnt == LEN) begin
          state_d = DONE;
        end else if (src_cnt != '0) begin
          en_d   = 1'b1;
          head_d = src[0];
          cnt_d  = cnt + 1'b1;
          buf_d  = src >> 1;
          bcnt_d = src_cnt - 1'b1;
        end
        if (accept && bcnt != '0) begin
          buf_d  = bus.cfg_data;
          bcnt_d = FULL;
        end
      end

      READ: begin
        // The enabled cycle with cnt == LEN is the final shift, so a
        // partial word is complete once cnt == LEN and it is non-empty.
        if (en_q) begin
          cap     = buf_q | ({WORD_W{ccff_tail}} & (WORD_W'(1) << bcnt));
          cap_cnt = bcnt + 1'b1;
        end
        word_done = (cap_cnt == FULL) || (cnt == LEN && cap_cnt != '0);
        if (word_done && slot_free) begin
          rb_data_d  = cap;
          rb_valid_d = 1'b1;
          buf_d      = '0;
          bcnt_d     = '0;
        end else begin
          buf_d  = cap;
          bcnt_d = cap_cnt;
        end
        if (cnt != LEN && bcnt_d != FULL) begin
          en_d  = 1'b1;
          cnt_d = cnt + 1'b1;
        end
        if (cnt == LEN && !en_q && bcnt == '0) state_d = DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state      <= IDLE;
      cnt        <= '0;
      buf_q      <= '0;
      bcnt       <= '0;
      head_q     <= 1'b0;
      en_q       <= 1'b0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      buf_q      <= buf_d;
      bcnt       <= bcnt_d;
      head_q     <= head_d;
      en_q       <= en_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural model of the
// configuration chain shifting on chain_clk_en.
module tb_ccff_chain_loader;
  localparam int CHAIN_LEN = 62;
  localparam int WORD_W    = 8;

  logic prog_clk = 1'b0;
  logic pReset;
  logic ccff_head, ccff_tail, chain_clk_en;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) bus ();

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(16)) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .bus         (bus),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .chain_clk_en(chain_clk_en)
  );

  always #5 prog_clk = ~prog_clk;

  // chain model and event counters
  logic [CHAIN_LEN-1:0] chain = '0;
  int unsigned shifts = 0, en_runs = 0, done_cnt = 0, acc_cnt = 0, rb_n = 0;
  logic en_prev = 1'b0;
  logic [7:0] rb_words [64];

  assign ccff_tail = chain[CHAIN_LEN-1];

  always @(posedge prog_clk) begin
    if (chain_clk_en) begin
      chain  <= {chain[CHAIN_LEN-2:0], ccff_head};
      shifts <= shifts + 1;
    end
    if (chain_clk_en && !en_prev) en_runs <= en_runs + 1;
    en_prev <= chain_clk_en;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.cfg_valid && bus.cfg_ready) acc_cnt <= acc_cnt + 1;
    if (bus.rb_valid && bus.rb_ready && rb_n < 64) begin
      rb_words[rb_n] <= bus.rb_data;
      rb_n <= rb_n + 1;
    end
  end

  int unsigned n_checks = 0, n_errors = 0;
  logic [7:0] cur [8];
  logic [CHAIN_LEN-1:0] exp_c;
  logic gap_bad, ready_bad;
  int unsigned b_sh, b_runs, b_done, b_acc, b_rb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge prog_clk);
  endtask

  task automatic set_exp();
    for (int j = 0; j < CHAIN_LEN; j++) exp_c[CHAIN_LEN-1-j] = cur[j/8][j%8];
  endtask

  task automatic take_base();
    b_sh = shifts; b_runs = en_runs; b_done = done_cnt; b_acc = acc_cnt; b_rb = rb_n;
  endtask

  task automatic pulse(input logic ld, input logic rd);
    bus.start_load = ld;
    bus.start_read = rd;
    tick();
    bus.start_load = 1'b0;
    bus.start_read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    ready_bad = 1'b0;
    while (bus.busy && t < 600) begin
      if (bus.cfg_ready) ready_bad = 1'b1;
      tick();
      t++;
    end
    check(tag, bus.busy, 0);
  endtask

  // Presents cur[0..7]; with gap set, holds cfg_valid low after each word
  // until the buffer drains, then checks the chain is frozen for 4 cycles.
  task automatic stream(input bit gap);
    int t;
    logic h;
    for (int i = 0; i < 8; i++) begin
      bus.cfg_data  = cur[i];
      bus.cfg_valid = 1'b1;
      t = 0;
      while (!bus.cfg_ready && t < 300) begin tick(); t++; end
      if (t >= 300) check("cfg_ready wait", bus.cfg_ready, 1);
      tick();
      if (gap && i < 7) begin
        bus.cfg_valid = 1'b0;
        t = 0;
        while (!bus.cfg_ready && t < 300) begin tick(); t++; end
        if (t >= 300) check("drain wait", bus.cfg_ready, 1);
        tick();
        tick();
        h = ccff_head;
        for (int k = 0; k < 4; k++) begin
          if (chain_clk_en || ccff_head !== h) gap_bad = 1'b1;
          tick();
        end
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic check_words(input string tag, input int unsigned first);
    logic [7:0] e;
    check({tag, " word count"}, rb_n - first, 8);
    for (int k = 0; k < 8; k++) begin
      e = (k == 7) ? (cur[k] & 8'h3F) : cur[k];
      check($sformatf("%s word%0d", tag, k), rb_words[first + k], e);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pReset = 1'b1;
    bus.start_load = 1'b0;
    bus.start_read = 1'b0;
    bus.cfg_data   = '0;
    bus.cfg_valid  = 1'b0;
    bus.rb_ready   = 1'b1;
    gap_bad   = 1'b0;
    ready_bad = 1'b0;
    tick();
    tick();
    check("reset cfg_ready", bus.cfg_ready, 0);
    check("reset rb_valid", bus.rb_valid, 0);
    check("reset rb_data", bus.rb_data, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset chain_clk_en", chain_clk_en, 0);
    check("reset ccff_head", ccff_head, 0);
    pReset = 1'b0;
    tick();

    // reset asserted mid-load after 20 shifts
    take_base();
    pulse(1'b1, 1'b0);
    check("busy after start", bus.busy, 1);
    bus.cfg_data  = 8'hA5;
    bus.cfg_valid = 1'b1;
    for (int t = 0; t < 200 && (shifts - b_sh) < 20; t++) tick();
    pReset = 1'b1;
    tick();
    check("midrst busy", bus.busy, 0);
    check("midrst chain_clk_en", chain_clk_en, 0);
    check("midrst cfg_ready", bus.cfg_ready, 0);
    check("midrst ccff_head", ccff_head, 0);
    check("midrst done", bus.done, 0);
    check("midrst shifts", shifts - b_sh, 20);
    bus.cfg_valid = 1'b0;
    pReset = 1'b0;
    tick();

    // gap-free load
    cur = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h55, 8'hC3};
    set_exp();
    take_base();
    pulse(1'b1, 1'b0);
    stream(1'b0);
    wait_idle("load A idle");
    check("load A shifts", shifts - b_sh, 62);
    check("load A en runs", en_runs - b_runs, 1);
    check("load A words accepted", acc_cnt - b_acc, 8);
    check("load A done pulses", done_cnt - b_done, 1);
    check("load A chain", chain, exp_c);
    tick();

    // readback with consumer always ready
    take_base();
    pulse(1'b0, 1'b1);
    wait_idle("read A idle");
    tick();
    check_words("read A", b_rb);
    check("read A shifts", shifts - b_sh, 62);
    check("read A chain kept", chain, exp_c);
    check("read A done pulses", done_cnt - b_done, 1);

    // readback with 30 cycles of backpressure after the first word
    bus.rb_ready = 1'b0;
    take_base();
    pulse(1'b0, 1'b1);
    for (int t = 0; t < 200 && !bus.rb_valid; t++) tick();
    check("bp first rb_valid", bus.rb_valid, 1);
    b_sh = shifts;
    for (int t = 0; t < 30; t++) tick();
    check("bp shifts in stall window", shifts - b_sh, 8);
    check("bp chain_clk_en stalled", chain_clk_en, 0);
    check("bp no words taken", rb_n - b_rb, 0);
    bus.rb_ready = 1'b1;
    wait_idle("bp idle");
    tick();
    check_words("bp", b_rb);
    check("bp chain kept", chain, exp_c);

    // simultaneous starts, start_read during LOAD, gapped word stream
    cur = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    set_exp();
    take_base();
    gap_bad = 1'b0;
    pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    stream(1'b1);
    wait_idle("load B idle");
    check("load B cfg_ready after 8th", ready_bad, 0);
    check("load B gap hold", gap_bad, 0);
    check("load B words accepted", acc_cnt - b_acc, 8);
    check("load B shifts", shifts - b_sh, 62);
    check("load B en runs", en_runs - b_runs, 8);
    check("load B chain", chain, exp_c);
    check("load B done pulses", done_cnt - b_done, 1);
    tick();

    take_base();
    pulse(1'b0, 1'b1);
    wait_idle("read B idle");
    tick();
    check_words("read B", b_rb);
    check("read B chain kept", chain, exp_c);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
